alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command front-end for the 8-bit ALU datapath. Buffers operation commands in a small FIFO, drives the ALU's operand, input-select and one-hot output-select lines for each command, captures the result and overflow flag, and returns them on a ready/valid result port. It keeps a local accumulator so that commands can chain on the previous result.

## Interface
- DEPTH, 4: command FIFO entries (power of 2, ≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- on  in  1  enable; 0 blocks new issues after the in-flight command completes
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; `on && count<DEPTH`
- cmd_op  in  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLR
- cmd_chain  in  1  1: A operand = local accumulator; 0: A = cmd_a
- cmd_a  in  8  A operand
- cmd_b  in  8  B operand
- in_selector  out  3  to ALU: [2] persist, [1] load, [0] reset (one-hot)
- num1  out  8  to ALU, A operand
- num2  out  8  to ALU, B operand
- out_selector  out  7  to ALU one-hot: [6] AND, [5] OR, [4] NOT, [3] XOR, [2] ADD, [1] SUB, [0] MULT
- alu_result  in  8  ALU output value
- alu_overflow  in  1  ALU multiply overflow
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  captured result
- res_op  out  3  opcode of the result
- res_overflow  out  1  overflow of this result (MULT only; 0 otherwise)
- err_sticky  out  1  set by any res_overflow; cleared by rst or CLR
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO entry = {op, chain, a, b}. Push on `cmd_valid && cmd_ready`. Pop at the end of ISSUE. Push and pop in the same cycle leave count unchanged. No push when full, because cmd_ready is 0. A pop on empty never occurs.
- FSM states:
  - OFF: entered when `on=0` while IDLE; waits for `on`.
  - IDLE: moves to ISSUE when `count>0 && on`; moves to OFF when `!on`.
  - ISSUE → EXEC, unconditional.
  - EXEC → DONE, capturing result.
  - DONE: holds until `res_ready`; then goes to IDLE, or to OFF if `!on`.
- ISSUE and EXEC drive the head entry:
  - num1 = chain ? acc : a
  - num2 = b
  - out_selector = one-hot of op
  - in_selector = 3'b010 (load)
- For CLR:
  - in_selector = 3'b001
  - out_selector = ADD
- persist (3'b100) is never driven. Chaining uses the local acc because the ALU accumulator register reloads every clock.
- Outside ISSUE/EXEC, all ALU drives hold their last values. The ALU output therefore stays stable.
- End of EXEC captures the following:
  - res_data: alu_result; forced to 0 for CLR.
  - res_op: op.
  - res_overflow: `alu_overflow && op==MULT`.
  - acc: res_data.
  - err_sticky: set when res_overflow=1; cleared when op=CLR.
- res_valid = (state==DONE). res_data, res_op and res_overflow are stable while res_valid=1.
- Dropping `on` mid-command does not abort the command. FIFO contents are retained while OFF.

## Timing
- Reset values:
  - state OFF (IDLE next cycle if on=1)
  - FIFO empty, count 0, cmd_ready 0 while in rst
  - in_selector 3'b001, num1 0, num2 0, out_selector 7'b0000100
  - res_valid 0, res_data 0, res_op 0, res_overflow 0, err_sticky 0, acc 0
- Latency with the FIFO empty and IDLE:
  - Command accepted in cycle 0.
  - ISSUE in cycle 1 (ALU operand registers load at the end of cycle 1).
  - EXEC in cycle 2.
  - res_valid high from cycle 3.
- Throughput: with res_ready tied to 1, the next ISSUE is in cycle 4. This gives one command per 3 cycles.
- rst asserted in any state returns all registers to their reset values immediately. The FIFO is flushed. Any in-flight result is discarded.

## Test plan
- ADD a=0x25 b=0x13 chain=0, res_ready=1 → cycle 1: num1=0x25, num2=0x13, in_selector=010, out_selector=0000100. Cycle 3: res_valid=1, res_data=0x38, res_op=4.
- Chain: CLR; ADD a=x b=0x05 chain=1; SUB b=0x02 chain=1 → results 0x00, 0x05, 0x03. The CLR cycle drives in_selector=001.
- MULT a=0x20 b=0x10 → res_overflow=1, err_sticky=1. A following CLR clears err_sticky.
- Fill the FIFO with 4 commands while res_ready=0 → cmd_ready drops to 0 at count=4. Each res_ready pulse pops one result, in order.
- Deassert on during EXEC → the result still completes. Afterwards the state is OFF with no ISSUE and cmd_ready=0. Reasserting on resumes with the queued head.
- Assert rst during EXEC → next cycle: count=0, res_valid=0, in_selector=001, acc=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit ALU: queues operation commands, sequences the
// ALU select/operand lines and returns each captured result on a ready/valid port.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   on,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic                   cmd_chain,
    input  logic [7:0]             cmd_a,
    input  logic [7:0]             cmd_b,
    output logic [2:0]             in_selector,
    output logic [7:0]             num1,
    output logic [7:0]             num2,
    output logic [6:0]             out_selector,
    input  logic [7:0]             alu_result,
    input  logic                   alu_overflow,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [7:0]             res_data,
    output logic [2:0]             res_op,
    output logic                   res_overflow,
    output logic                   err_sticky,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 20;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [2:0] OP_MULT = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [6:0] op_sel(input logic [2:0] op);
        case (op)
            3'd0:    op_sel = 7'b1000000;
            3'd1:    op_sel = 7'b0100000;
            3'd2:    op_sel = 7'b0010000;
            3'd3:    op_sel = 7'b0001000;
            3'd4:    op_sel = 7'b0000100;
            3'd5:    op_sel = 7'b0000010;
            3'd6:    op_sel = 7'b0000001;
            default: op_sel = 7'b0000100;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [EW-1:0]   fifo_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      in_sel_q, in_sel_d;
    logic [7:0]      num1_q, num1_d, num2_q, num2_d;
    logic [6:0]      out_sel_q, out_sel_d;
    logic [2:0]      cur_op_q, cur_op_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic [2:0]      res_op_q, res_op_d;
    logic            res_ovf_q, res_ovf_d;
    logic            err_q, err_d;
    logic [7:0]      acc_q, acc_d;

    logic            cmd_ready_s, push_s, pop_s, avail_s, load_s;
    logic [EW-1:0]   head_s;

    assign cmd_ready_s = on && !rst && (count_q < FULL);
    assign push_s      = cmd_valid && cmd_ready_s;
    assign pop_s       = (state_q == ST_ISSUE);
    assign avail_s     = (count_q != '0) || push_s;
    // An empty FIFO forwards the incoming command so issue starts the next cycle
    assign head_s      = (count_q == '0) ? {cmd_op, cmd_chain, cmd_a, cmd_b} : fifo_q[rd_ptr_q];

    // Next-state logic for the FSM, FIFO pointers, ALU drives and result capture
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        in_sel_d    = in_sel_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        out_sel_d   = out_sel_q;
        cur_op_d    = cur_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_ovf_d   = res_ovf_q;
        err_d       = err_q;
        acc_d       = acc_q;
        load_s      = 1'b0;

        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end

        case (state_q)
            ST_OFF: begin
                state_d = on ? ST_IDLE : ST_OFF;
            end
            ST_IDLE: begin
                if (!on) begin
                    state_d = ST_OFF;
                end else if (avail_s) begin
                    state_d = ST_ISSUE;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d     = ST_DONE;
                res_valid_d = 1'b1;
                res_op_d    = cur_op_q;
                if (cur_op_q == OP_CLR) begin
                    res_data_d = 8'h00;
                    res_ovf_d  = 1'b0;
                    err_d      = 1'b0;
                end else begin
                    res_data_d = alu_result;
                    res_ovf_d  = alu_overflow && (cur_op_q == OP_MULT);
                    err_d      = err_q || (alu_overflow && (cur_op_q == OP_MULT));
                end
                acc_d = res_data_d;
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (!on) begin
                        state_d = ST_OFF;
                    end else if (avail_s) begin
                        state_d = ST_ISSUE;
                        load_s  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Drives are latched once on entry to ISSUE and held through EXEC and beyond
        if (load_s) begin
            cur_op_d  = head_s[19:17];
            num1_d    = head_s[16] ? acc_q : head_s[15:8];
            num2_d    = head_s[7:0];
            out_sel_d = op_sel(head_s[19:17]);
            in_sel_d  = (head_s[19:17] == OP_CLR) ? 3'b001 : 3'b010;
        end else begin
            cur_op_d = cur_op_q;
        end
    end

    // State, FIFO storage and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_sel_q    <= 3'b001;
            num1_q      <= 8'h00;
            num2_q      <= 8'h00;
            out_sel_q   <= 7'b0000100;
            cur_op_q    <= 3'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_op_q    <= 3'd0;
            res_ovf_q   <= 1'b0;
            err_q       <= 1'b0;
            acc_q       <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_sel_q    <= in_sel_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            out_sel_q   <= out_sel_d;
            cur_op_q    <= cur_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_ovf_q   <= res_ovf_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            if (push_s) begin
                fifo_q[wr_ptr_q] <= {cmd_op, cmd_chain, cmd_a, cmd_b};
            end
        end
    end

    assign cmd_ready    = cmd_ready_s;
    assign in_selector  = in_sel_q;
    assign num1         = num1_q;
    assign num2         = num2_q;
    assign out_selector = out_sel_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_op       = res_op_q;
    assign res_overflow = res_ovf_q;
    assign err_sticky   = err_q;
    assign count        = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU plus a queue-based
// command model that predicts every result, overflow and sticky-error value.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, on, cmd_valid, cmd_chain, res_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic       cmd_ready, res_valid, res_overflow, err_sticky, alu_overflow;
    logic [2:0] in_selector, res_op;
    logic [7:0] num1, num2, res_data, alu_result;
    logic [6:0] out_selector;
    logic [2:0] count;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .on(on),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .in_selector(in_selector), .num1(num1), .num2(num2), .out_selector(out_selector),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .res_overflow(res_overflow), .err_sticky(err_sticky),
        .count(count)
    );

    always #5 clk = ~clk;

    // ALU stand-in: operand registers load on 'load', clear on 'reset'
    logic [7:0]  ra = 8'h00, rb = 8'h00;
    logic [15:0] prod;
    always @(posedge clk) begin
        if (in_selector == 3'b010) begin
            ra <= num1;
            rb <= num2;
        end else if (in_selector == 3'b001) begin
            ra <= 8'h00;
            rb <= 8'h00;
        end
    end

    always_comb begin
        prod         = {8'h00, ra} * {8'h00, rb};
        alu_overflow = 1'b0;
        alu_result   = 8'h00;
        case (out_selector)
            7'b1000000: alu_result = ra & rb;
            7'b0100000: alu_result = ra | rb;
            7'b0010000: alu_result = ~ra;
            7'b0001000: alu_result = ra ^ rb;
            7'b0000100: alu_result = ra + rb;
            7'b0000010: alu_result = ra - rb;
            7'b0000001: begin
                alu_result   = prod[7:0];
                alu_overflow = (prod > 16'd255);
            end
            default: alu_result = 8'h00;
        endcase
    end

    typedef struct packed {
        logic [2:0] op;
        logic       chain;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t mq[$];
    int   m_acc = 0;
    logic m_err = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic ch, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick(1);
            n++;
        end
        chk("cmd_ready", {15'd0, cmd_ready}, 16'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_chain = ch;
        cmd_a     = a;
        cmd_b     = b;
        tick(1);
        cmd_valid = 1'b0;
        mq.push_back(cmd_t'({op, ch, a, b}));
    endtask

    task automatic get_result();
        cmd_t c;
        int   av, r, n;
        logic ovf;
        n = 0;
        while (!res_valid && n < 50) begin
            tick(1);
            n++;
        end
        chk("res_valid", {15'd0, res_valid}, 16'd1);
        c  = mq.pop_front();
        av = c.chain ? m_acc : int'(c.a);
        case (c.op)
            3'd0:    r = av & int'(c.b);
            3'd1:    r = av | int'(c.b);
            3'd2:    r = ~av;
            3'd3:    r = av ^ int'(c.b);
            3'd4:    r = av + int'(c.b);
            3'd5:    r = av - int'(c.b);
            3'd6:    r = av * int'(c.b);
            default: r = 0;
        endcase
        ovf   = (c.op == 3'd6) && (r > 255);
        r     = r & 255;
        m_acc = r;
        if (c.op == 3'd7) m_err = 1'b0;
        else if (ovf) m_err = 1'b1;
        chk("res_data", {8'd0, res_data}, 16'(r));
        chk("res_op", {13'd0, res_op}, {13'd0, c.op});
        chk("res_overflow", {15'd0, res_overflow}, {15'd0, ovf});
        chk("err_sticky", {15'd0, err_sticky}, {15'd0, m_err});
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; on = 1'b1; cmd_valid = 1'b0; cmd_chain = 1'b0; res_ready = 1'b0;
        cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00;
        tick(2);
        chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        chk("rst_count", {13'd0, count}, 16'd0);
        chk("rst_in_sel", {13'd0, in_selector}, 16'h0001);
        chk("rst_num1", {8'd0, num1}, 16'd0);
        chk("rst_num2", {8'd0, num2}, 16'd0);
        chk("rst_out_sel", {9'd0, out_selector}, 16'h0004);
        chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
        chk("rst_res_data", {8'd0, res_data}, 16'd0);
        chk("rst_res_op", {13'd0, res_op}, 16'd0);
        chk("rst_err", {15'd0, err_sticky}, 16'd0);
        rst = 1'b0;
        tick(3);

        // Latency: accept in cycle 0, drives in cycle 1, result in cycle 3
        send(3'd4, 1'b0, 8'h25, 8'h13);
        chk("lat_num1", {8'd0, num1}, 16'h0025);
        chk("lat_num2", {8'd0, num2}, 16'h0013);
        chk("lat_in_sel", {13'd0, in_selector}, 16'h0002);
        chk("lat_out_sel", {9'd0, out_selector}, 16'h0004);
        tick(1);
        chk("lat_c2_valid", {15'd0, res_valid}, 16'd0);
        tick(1);
        chk("lat_c3_valid", {15'd0, res_valid}, 16'd1);
        get_result();

        // Chaining through the local accumulator
        send(3'd7, 1'b0, 8'h5A, 8'hA5);
        chk("clr_in_sel", {13'd0, in_selector}, 16'h0001);
        chk("clr_out_sel", {9'd0, out_selector}, 16'h0004);
        get_result();
        send(3'd4, 1'b1, 8'h99, 8'h05);
        chk("chain_num1", {8'd0, num1}, 16'h0000);
        get_result();
        send(3'd5, 1'b1, 8'h77, 8'h02);
        get_result();

        // Overflow sets the sticky flag; CLR clears it
        send(3'd6, 1'b0, 8'h20, 8'h10);
        get_result();
        send(3'd7, 1'b0, 8'h00, 8'h00);
        get_result();

        // Throughput: second command's result three cycles after the first
        send(3'd3, 1'b0, 8'h3C, 8'h0F);
        send(3'd1, 1'b0, 8'h10, 8'h01);
        get_result();
        tick(1);
        chk("thr_c5_valid", {15'd0, res_valid}, 16'd0);
        tick(1);
        chk("thr_c6_valid", {15'd0, res_valid}, 16'd1);
        get_result();

        // Fill: one in flight plus DEPTH queued
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        chk("full_count", {13'd0, count}, 16'd4);
        chk("full_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            get_result();
        end

        // Randomised bursts against the model
        for (int it = 0; it < 12; it++) begin
            int k;
            k = int'($urandom_range(1, 4));
            for (int j = 0; j < k; j++) begin
                send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end
            for (int j = 0; j < k; j++) begin
                get_result();
            end
        end

        // Dropping 'on' during EXEC completes the command, then parks in OFF
        send(3'd4, 1'b0, 8'h40, 8'h02);
        send(3'd3, 1'b0, 8'h0F, 8'hF0);
        on = 1'b0;
        get_result();
        tick(4);
        chk("off_count", {13'd0, count}, 16'd1);
        chk("off_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        chk("off_res_valid", {15'd0, res_valid}, 16'd0);
        on = 1'b1;
        get_result();

        // Reset during EXEC flushes everything, including the accumulator
        send(3'd4, 1'b0, 8'h11, 8'h22);
        get_result();
        send(3'd5, 1'b0, 8'h50, 8'h01);
        send(3'd1, 1'b0, 8'h01, 8'h02);
        rst = 1'b1;
        tick(1);
        chk("rr_count", {13'd0, count}, 16'd0);
        chk("rr_res_valid", {15'd0, res_valid}, 16'd0);
        chk("rr_in_sel", {13'd0, in_selector}, 16'h0001);
        chk("rr_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        rst = 1'b0;
        mq.delete();
        m_acc = 0;
        m_err = 1'b0;
        tick(3);
        send(3'd4, 1'b1, 8'hAA, 8'h07);
        get_result();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
